// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU opcodes and multiplier FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mult_state_t;

   localparam int unsigned MULT_ITERS = 32;

endpackage

// File: rtl/alu_if.sv
// Connection between the combinational ALU and whichever unit is borrowing it.
interface alu_if;
   import cpu_types_pkg::*;

   word_t  port_a;
   word_t  port_b;
   aluop_t alu_op;
   word_t  result;
   logic   negative;
   logic   overflow;
   logic   zero;

   modport master (
      output port_a, port_b, alu_op,
      input  result, negative, overflow, zero
   );

   modport slave (
      input  port_a, port_b, alu_op,
      output result, negative, overflow, zero
   );
endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU with negative/overflow/zero flags.
module alu
   import cpu_types_pkg::*;
(
   alu_if.slave aluif
);

   always_comb begin
      aluif.result   = '0;
      aluif.overflow = 1'b0;
      unique case (aluif.alu_op)
         ALU_ADD: begin
            aluif.result   = aluif.port_a + aluif.port_b;
            aluif.overflow = (aluif.port_a[31] == aluif.port_b[31]) &&
                             (aluif.result[31] != aluif.port_a[31]);
         end
         ALU_SUB: begin
            aluif.result   = aluif.port_a - aluif.port_b;
            aluif.overflow = (aluif.port_a[31] != aluif.port_b[31]) &&
                             (aluif.result[31] != aluif.port_a[31]);
         end
         ALU_AND: aluif.result = aluif.port_a & aluif.port_b;
         ALU_OR:  aluif.result = aluif.port_a | aluif.port_b;
         ALU_XOR: aluif.result = aluif.port_a ^ aluif.port_b;
         ALU_SLL: aluif.result = aluif.port_a << aluif.port_b[4:0];
         ALU_SRL: aluif.result = aluif.port_a >> aluif.port_b[4:0];
         default: aluif.result = '0;
      endcase
   end

   assign aluif.negative = aluif.result[31];
   assign aluif.zero     = (aluif.result == '0);

endmodule

// File: rtl/alu_shift_multiplier.sv
// Sequential 32x32->64 unsigned shift-add multiplier; every partial-product add borrows the
// shared ALU and the carry out is recovered locally from an unsigned compare.
module alu_shift_multiplier
   import cpu_types_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  start,
   input  word_t multiplicand,
   input  word_t multiplier,
   output logic  busy,
   output logic  done,
   output word_t product_hi,
   output word_t product_lo,
   alu_if.master aluif
);

   localparam logic [4:0] LastCount = 5'(MULT_ITERS - 1);

   mult_state_t state;
   word_t       acc_hi, acc_lo, mcand;
   logic [4:0]  count;

   word_t sum, acc_hi_nx, acc_lo_nx;
   logic  carry;
   logic  unused_flags;

   always_comb begin
      aluif.alu_op = ALU_ADD;
      aluif.port_a = '0;
      aluif.port_b = '0;
      if (state == RUN) begin
         aluif.port_a = acc_hi;
         aluif.port_b = acc_lo[0] ? mcand : '0;
      end
   end

   // A 32-bit add wrapped iff the sum is below one of its addends.
   assign sum       = aluif.result;
   assign carry     = acc_lo[0] & (sum < acc_hi);
   assign acc_hi_nx = {carry, sum[31:1]};
   assign acc_lo_nx = {sum[0], acc_lo[31:1]};

   assign unused_flags = ^{aluif.negative, aluif.overflow, aluif.zero};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         product_hi <= '0;
         product_lo <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         mcand      <= '0;
         count      <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= multiplicand;
                  acc_lo <= multiplier;
                  acc_hi <= '0;
                  count  <= '0;
                  if (ZERO_SKIP && ((multiplicand == '0) || (multiplier == '0))) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     product_hi <= '0;
                     product_lo <= '0;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc_hi <= acc_hi_nx;
               acc_lo <= acc_lo_nx;
               count  <= count + 5'd1;
               if (count == LastCount) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  product_hi <= acc_hi_nx;
                  product_lo <= acc_lo_nx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_shift_multiplier.sv
// Directed bench: two multipliers (ZERO_SKIP on and off), each on its own real ALU.
module tb_alu_shift_multiplier;
   import cpu_types_pkg::*;

   logic  clk = 1'b0;
   logic  nrst = 1'b0;
   logic  start0 = 1'b0, start1 = 1'b0;
   word_t mcand_in = '0, mplier_in = '0;
   logic  busy0, done0, busy1, done1;
   word_t hi0, lo0, hi1, lo1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_if aluif0 ();
   alu_if aluif1 ();

   alu u_alu0 (.aluif(aluif0));
   alu u_alu1 (.aluif(aluif1));

   alu_shift_multiplier #(.ZERO_SKIP(1'b1)) u_dut0 (
      .CLK(clk), .nRST(nrst), .start(start0), .multiplicand(mcand_in), .multiplier(mplier_in),
      .busy(busy0), .done(done0), .product_hi(hi0), .product_lo(lo0), .aluif(aluif0)
   );

   alu_shift_multiplier #(.ZERO_SKIP(1'b0)) u_dut1 (
      .CLK(clk), .nRST(nrst), .start(start1), .multiplicand(mcand_in), .multiplier(mplier_in),
      .busy(busy1), .done(done1), .product_hi(hi1), .product_lo(lo1), .aluif(aluif1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts one multiply and counts cycles after the accepting edge until done (-1 on timeout).
   // poke > 0 pulses start with new operands 7x6 in that cycle while the first op is busy.
   task automatic run_mult(input bit sel, input word_t a, input word_t b, input int poke,
                           output int lat, output int busy_cycles);
      @(negedge clk);
      mcand_in  = a;
      mplier_in = b;
      if (sel) start1 = 1'b1;
      else     start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      lat = -1;
      busy_cycles = 0;
      for (int c = 1; c <= 100; c++) begin
         if (poke > 0) begin
            start0 = (c == poke);
            if (c == poke) begin
               mcand_in  = 32'd7;
               mplier_in = 32'd6;
            end
         end
         if (sel ? done1 : done0) begin
            lat = c;
            break;
         end
         if (sel ? busy1 : busy0) busy_cycles++;
         @(negedge clk);
      end
      start0 = 1'b0;
   endtask

   int lat, bc, gap;
   logic seen_done;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_done", 64'(done0), 64'd0);
      chk("rst_product", {hi0, lo0}, 64'd0);
      chk("rst_port_a", 64'(aluif0.port_a), 64'd0);
      chk("rst_port_b", 64'(aluif0.port_b), 64'd0);
      chk("rst_alu_op", 64'(aluif0.alu_op), 64'(ALU_ADD));
      nrst = 1'b1;

      run_mult(1'b0, 32'd3, 32'd5, 0, lat, bc);
      chk("3x5_latency", 64'(lat), 64'd33);
      chk("3x5_busy_cycles", 64'(bc), 64'd32);
      chk("3x5_product", {hi0, lo0}, 64'h0000_0000_0000_000F);
      @(negedge clk);
      chk("3x5_done_one_cycle", 64'(done0), 64'd0);
      chk("3x5_product_held", {hi0, lo0}, 64'h0000_0000_0000_000F);

      run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bc);
      chk("ffxff_product", {hi0, lo0}, 64'hFFFF_FFFE_0000_0001);

      run_mult(1'b0, 32'h8000_0000, 32'h0000_0002, 0, lat, bc);
      chk("8000x2_product", {hi0, lo0}, 64'h0000_0001_0000_0000);

      run_mult(1'b0, 32'h0001_0000, 32'h0001_0000, 0, lat, bc);
      chk("10000sq_product", {hi0, lo0}, 64'h0000_0001_0000_0000);

      run_mult(1'b0, 32'h0000_0000, 32'h0000_1234, 0, lat, bc);
      chk("zskip_latency", 64'(lat), 64'd1);
      chk("zskip_busy_cycles", 64'(bc), 64'd0);
      chk("zskip_product", {hi0, lo0}, 64'd0);

      run_mult(1'b1, 32'd9, 32'd9, 0, lat, bc);
      chk("noskip_prior_product", {hi1, lo1}, 64'd81);
      run_mult(1'b1, 32'h0000_0000, 32'h0000_1234, 0, lat, bc);
      chk("noskip_latency", 64'(lat), 64'd33);
      chk("noskip_product", {hi1, lo1}, 64'd0);

      run_mult(1'b0, 32'd3, 32'd5, 10, lat, bc);
      chk("overlap_latency", 64'(lat), 64'd33);
      chk("overlap_product", {hi0, lo0}, 64'h0000_0000_0000_000F);

      // Back-to-back: start held through DONE, second operands presented in the DONE cycle.
      @(negedge clk);
      mcand_in  = 32'd3;
      mplier_in = 32'd5;
      start0    = 1'b1;
      lat = -1;
      for (int c = 0; c <= 100; c++) begin
         @(negedge clk);
         if (done0) begin
            lat = c + 1;
            break;
         end
      end
      chk("b2b_first_latency", 64'(lat), 64'd33);
      chk("b2b_first_product", {hi0, lo0}, 64'h0000_0000_0000_000F);
      mcand_in  = 32'd7;
      mplier_in = 32'd6;
      @(negedge clk);
      start0 = 1'b0;
      chk("b2b_done_single", 64'(done0), 64'd0);
      chk("b2b_busy_again", 64'(busy0), 64'd1);
      gap = -1;
      for (int c = 1; c <= 100; c++) begin
         if (done0) begin
            gap = c;
            break;
         end
         @(negedge clk);
      end
      chk("b2b_second_latency", 64'(gap), 64'd33);
      chk("b2b_second_product", {hi0, lo0}, 64'h0000_0000_0000_002A);

      // Reset during RUN cycle 10.
      @(negedge clk);
      mcand_in  = 32'd3;
      mplier_in = 32'd5;
      start0    = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrst_was_busy", 64'(busy0), 64'd1);
      nrst = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy0), 64'd0);
      chk("midrst_done", 64'(done0), 64'd0);
      chk("midrst_product", {hi0, lo0}, 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done0 || busy0) seen_done = 1'b1;
      end
      chk("midrst_no_done", 64'(seen_done), 64'd0);

      run_mult(1'b0, 32'd7, 32'd6, 0, lat, bc);
      chk("after_rst_latency", 64'(lat), 64'd33);
      chk("after_rst_product", {hi0, lo0}, 64'h0000_0000_0000_002A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
